// File: rtl/timer_count_core.sv
// timer_count_core: prescaled seconds/minutes up-counter with start/pause/clear control FSM
module timer_count_core #(
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX_MIN  = 99
) (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic       StartStop,
    input  logic       Clear,
    input  logic       ModeIn,
    input  logic [2:0] TimeSelIn,
    output logic [7:0] LSBBinary,
    output logic [7:0] MSBBinary,
    output logic       ModeSel,
    output logic [2:0] TimeControl,
    output logic       Running,
    output logic       Done
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0] MAXM = 8'(MAX_MIN);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} stateT;
    stateT state, nextState;
    logic [PW-1:0] presc, prescNext;
    logic [7:0] lsbNext, msbNext, incLsb, incMsb;
    logic [1:0] startSync, clearSync;
    logic startPrev, clearPrev, startPulse, clearPulse, tick, secWrap, terminal;
    assign startPulse = startSync[1] & ~startPrev;
    assign clearPulse = clearSync[1] & ~clearPrev;
    assign Running = state == RUN;
    assign Done = state == DONE;
    // two-flop synchronisers for the key levels plus a delayed copy for edge detection
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            startSync <= '0;
            clearSync <= '0;
            startPrev <= 1'b0;
            clearPrev <= 1'b0;
        end else begin
            startSync <= {startSync[0], StartStop};
            clearSync <= {clearSync[0], Clear};
            startPrev <= startSync[1];
            clearPrev <= clearSync[1];
        end
    end
    // mode and duration track the inputs only while idle, frozen once a run begins
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            ModeSel <= 1'b0;
            TimeControl <= '0;
        end else if (state == IDLE) begin
            ModeSel <= ModeIn;
            TimeControl <= TimeSelIn;
        end
    end
    // state, prescaler and time counts registered together
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
            presc <= '0;
            LSBBinary <= '0;
            MSBBinary <= '0;
        end else begin
            state <= nextState;
            presc <= prescNext;
            LSBBinary <= lsbNext;
            MSBBinary <= msbNext;
        end
    end
    // next state and counts; clear beats start, countdown completion beats pause
    always_comb begin
        nextState = state;
        prescNext = presc;
        lsbNext = LSBBinary;
        msbNext = MSBBinary;
        tick = state == RUN && presc == LAST;
        secWrap = LSBBinary == 8'd59;
        incLsb = secWrap ? 8'd0 : LSBBinary + 8'd1;
        incMsb = !secWrap ? MSBBinary : (!ModeSel && MSBBinary == MAXM) ? 8'd0 : MSBBinary + 8'd1;
        terminal = tick && ModeSel && secWrap && incMsb == {5'd0, TimeControl} + 8'd1;
        if (clearPulse) begin
            nextState = IDLE;
            prescNext = '0;
            lsbNext = '0;
            msbNext = '0;
        end else begin
            if (state == RUN) begin
                prescNext = tick ? '0 : presc + PW'(1);
                lsbNext = tick ? incLsb : LSBBinary;
                msbNext = tick ? incMsb : MSBBinary;
            end
            case (state)
                IDLE: begin
                    nextState = startPulse ? RUN : IDLE;
                    prescNext = '0;
                end
                RUN: nextState = terminal ? DONE : startPulse ? PAUSE : RUN;
                PAUSE: nextState = startPulse ? RUN : PAUSE;
                default: nextState = DONE;
            endcase
        end
    end
endmodule
